// File: rtl/frame_sched_pkg.sv
// Shared types and defaults for the frame scheduler.
package frame_sched_pkg;

  localparam int unsigned CH_NUM      = 8;
  localparam int unsigned ACK_TIMEOUT = 16;
  localparam int unsigned REFRESH_W   = 24;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitAck,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/frame_sched_refresh_timer.sv
// Free-running auto-refresh timer; expiry is a live compare so period changes apply at once.
module refresh_timer #(
  parameter int unsigned Width = 24
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             enable_in,
  input  logic             clear_in,
  input  logic [Width-1:0] period_in,
  output logic             expire_out
);

  logic [Width-1:0] cnt_q;

  // A count already past a newly lowered period expires immediately.
  assign expire_out = enable_in && (period_in != '0) && (cnt_q >= period_in - Width'(1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
    end else if (clear_in) begin
      cnt_q <= '0;
    end else if (enable_in && (period_in != '0)) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

endmodule

// File: rtl/frame_sched.sv
// Frame scheduler: starts enabled channels on host or auto-refresh triggers and tracks completion.
module frame_sched
  import frame_sched_pkg::*;
#(
  parameter int unsigned ChNum      = CH_NUM,
  parameter int unsigned AckTimeout = ACK_TIMEOUT
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 frame_req_in,
  input  logic [ChNum-1:0]     ch_en_in,
  input  logic [ChNum-1:0]     ch_busy_in,
  input  logic                 auto_en_in,
  input  logic [REFRESH_W-1:0] refresh_div_in,
  output logic [ChNum-1:0]     frame_start_out,
  output logic                 frame_done_out,
  output logic                 busy_out,
  output logic                 pending_out,
  output logic [7:0]           drop_cnt_out
);

  localparam int unsigned AckCntW = $clog2(AckTimeout + 1);

  state_e               state_q, state_d;
  logic [ChNum-1:0]     mask_q;
  logic [AckCntW-1:0]   ack_cnt_q;
  logic                 pending_q;
  logic                 init_q;
  logic                 expire;
  logic                 any_busy;

  assign any_busy    = |(ch_busy_in & mask_q);
  assign pending_out = pending_q;

  refresh_timer #(
    .Width (REFRESH_W)
  ) u_refresh_timer (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .enable_in  ((state_q == StIdle) && init_q && auto_en_in),
    .clear_in   (state_q == StStart),
    .period_in  (refresh_div_in),
    .expire_out (expire)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // init_q holds off triggers on the first edge after reset release.
      StIdle:    if (init_q && (frame_req_in || expire)) state_d = StStart;
      StStart:   state_d = StWaitAck;
      StWaitAck: begin
        if (any_busy) begin
          state_d = StRun;
        end else if ((mask_q == '0) || (ack_cnt_q == AckCntW'(AckTimeout - 1))) begin
          state_d = StDone;
        end
      end
      StRun:     if (!any_busy) state_d = StDone;
      StDone:    state_d = (pending_q || frame_req_in) ? StStart : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= StIdle;
      init_q          <= 1'b0;
      mask_q          <= '0;
      ack_cnt_q       <= '0;
      pending_q       <= 1'b0;
      drop_cnt_out    <= '0;
      frame_start_out <= '0;
      frame_done_out  <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      init_q          <= 1'b1;
      state_q         <= state_d;
      frame_start_out <= (state_d == StStart) ? ch_en_in : '0;
      frame_done_out  <= (state_d == StDone);
      busy_out        <= (state_d != StIdle);
      ack_cnt_q       <= (state_q == StWaitAck) ? ack_cnt_q + AckCntW'(1) : '0;
      if (state_d == StStart) begin
        mask_q <= ch_en_in;
      end
      if (state_d == StStart) begin
        pending_q <= 1'b0;
      end else if (frame_req_in && (state_q != StIdle)) begin
        pending_q <= 1'b1;
      end
      if (frame_req_in && (state_q != StIdle) && pending_q && (drop_cnt_out != 8'hFF)) begin
        drop_cnt_out <= drop_cnt_out + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_sched.sv
// Directed self-checking bench for frame_sched.
module tb_frame_sched;

  logic        clk;
  logic        rst_n;
  logic        frame_req;
  logic [7:0]  ch_en;
  logic [7:0]  ch_busy;
  logic        auto_en;
  logic [23:0] refresh_div;
  logic [7:0]  frame_start;
  logic        frame_done;
  logic        busy;
  logic        pending;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  frame_sched dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .frame_req_in    (frame_req),
    .ch_en_in        (ch_en),
    .ch_busy_in      (ch_busy),
    .auto_en_in      (auto_en),
    .refresh_div_in  (refresh_div),
    .frame_start_out (frame_start),
    .frame_done_out  (frame_done),
    .busy_out        (busy),
    .pending_out     (pending),
    .drop_cnt_out    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    frame_req   = 1'b0;
    ch_en       = 8'h00;
    ch_busy     = 8'h00;
    auto_en     = 1'b0;
    refresh_div = 24'd0;
    rst_n       = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  // Ticks until busy_out rises; cycles = edges waited, or -1 if the limit expired.
  task automatic wait_start(input int limit, output int cycles);
    logic prev;
    prev   = busy;
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (busy === 1'b1 && prev === 1'b0) begin
        cycles = i;
        break;
      end
      prev = busy;
    end
  endtask

  task automatic test_reset();
    logic [18:0] outs;
    frame_req   = 1'b1;
    ch_en       = 8'hA5;
    ch_busy     = 8'hFF;
    auto_en     = 1'b0;
    refresh_div = 24'd0;
    rst_n       = 1'b0;
    #3;
    outs = {frame_start, frame_done, busy, pending, drop_cnt};
    total++;
    if (outs !== 19'd0) begin
      bad++;
      $display("FAIL reset_async: outputs got %h want 0", outs);
    end
    tick();
    outs = {frame_start, frame_done, busy, pending, drop_cnt};
    total++;
    if (outs !== 19'd0) begin
      bad++;
      $display("FAIL reset_held: outputs got %h want 0", outs);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (frame_start !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_edge1: start got %h busy %b want 00/0", frame_start, busy);
    end
    tick();
    total++;
    if (frame_start !== 8'hA5) begin
      bad++;
      $display("FAIL reset_edge2: start got %h want a5", frame_start);
    end
    frame_req = 1'b0;
    tick();
    total++;
    if (frame_start !== 8'h00 || pending !== 1'b0) begin
      bad++;
      $display("FAIL reset_pulse_end: start got %h pending %b want 00/0", frame_start, pending);
    end
    ch_busy = 8'h00;
  endtask

  task automatic test_normal();
    int dones;
    int starts;
    apply_reset();
    ch_en     = 8'hFF;
    frame_req = 1'b1;
    tick();
    total++;
    if (frame_start !== 8'hFF || busy !== 1'b1 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL normal_start: start %h busy %b done %b want ff/1/0",
               frame_start, busy, frame_done);
    end
    frame_req = 1'b0;
    tick();
    total++;
    if (frame_start !== 8'h00) begin
      bad++;
      $display("FAIL normal_start_width: start got %h want 00", frame_start);
    end
    repeat (2) tick();
    ch_busy = 8'hFF;
    dones  = 0;
    starts = 0;
    repeat (100) begin
      tick();
      if (frame_done === 1'b1) dones++;
      if (frame_start !== 8'h00) starts++;
    end
    total++;
    if (dones != 0 || starts != 0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL normal_run: dones %0d starts %0d busy %b want 0/0/1", dones, starts, busy);
    end
    ch_busy = 8'h00;
    tick();
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL normal_done: done got %b want 1", frame_done);
    end
    tick();
    total++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL normal_idle: done %b busy %b want 0/0", frame_done, busy);
    end
  endtask

  task automatic test_queue();
    apply_reset();
    ch_en     = 8'h0F;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    ch_busy   = 8'h01;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      frame_req = 1'b1;
      tick();
      frame_req = 1'b0;
      tick();
    end
    total++;
    if (pending !== 1'b1 || drop_cnt !== 8'd2) begin
      bad++;
      $display("FAIL queue_pending: pending %b drop %0d want 1/2", pending, drop_cnt);
    end
    ch_busy = 8'h00;
    tick();
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL queue_done: done got %b want 1", frame_done);
    end
    tick();
    total++;
    if (frame_start !== 8'h0F || pending !== 1'b0 || drop_cnt !== 8'd2) begin
      bad++;
      $display("FAIL queue_restart: start %h pending %b drop %0d want 0f/0/2",
               frame_start, pending, drop_cnt);
    end
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    ch_en     = 8'h01;
    ch_busy   = 8'hFE;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    tick();
    n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL ack_timeout: done after %0d cycles want 16", n);
    end
    tick();
    total++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL ack_timeout_idle: busy %b done %b want 0/0", busy, frame_done);
    end
    ch_busy = 8'h00;
  endtask

  task automatic test_zero_mask();
    apply_reset();
    ch_en     = 8'h00;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    total++;
    if (busy !== 1'b1 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL zero_mask_start: busy %b done %b want 1/0", busy, frame_done);
    end
    tick();
    tick();
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL zero_mask_done: done got %b want 1", frame_done);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_mask_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_auto_refresh();
    int cyc;
    apply_reset();
    ch_en       = 8'h00;
    refresh_div = 24'd1000;
    auto_en     = 1'b1;
    wait_start(3000, cyc);
    total++;
    if (cyc < 0) begin
      bad++;
      $display("FAIL refresh_first: no start seen within 3000 cycles");
    end
    // Zero-mask frame adds START, WAIT_ACK and DONE to the idle period.
    wait_start(3000, cyc);
    total++;
    if (cyc != 1003) begin
      bad++;
      $display("FAIL refresh_period: got %0d cycles want 1003", cyc);
    end
    repeat (53) tick();
    refresh_div = 24'd20;
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL refresh_shrink: busy got %b want 1", busy);
    end
    refresh_div = 24'd0;
    wait_start(2500, cyc);
    total++;
    if (cyc != -1) begin
      bad++;
      $display("FAIL refresh_disabled: start after %0d cycles want none", cyc);
    end
    auto_en = 1'b0;
  endtask

  task automatic test_coincident();
    int cyc;
    apply_reset();
    ch_en       = 8'h00;
    refresh_div = 24'd30;
    auto_en     = 1'b1;
    wait_start(200, cyc);
    total++;
    if (cyc < 0) begin
      bad++;
      $display("FAIL coincide_setup: no start seen within 200 cycles");
    end
    repeat (32) tick();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    total++;
    if (busy !== 1'b1 || pending !== 1'b0) begin
      bad++;
      $display("FAIL coincide_start: busy %b pending %b want 1/0", busy, pending);
    end
    tick();
    total++;
    if (pending !== 1'b0 || drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL coincide_pending: pending %b drop %0d want 0/0", pending, drop_cnt);
    end
    repeat (2) tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL coincide_single: busy got %b want 0", busy);
    end
    auto_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [18:0] outs;
    int dones;
    apply_reset();
    ch_en     = 8'hFF;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    ch_busy   = 8'hFF;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    outs = {frame_start, frame_done, busy, pending, drop_cnt};
    total++;
    if (outs !== 19'd0) begin
      bad++;
      $display("FAIL reset_mid: outputs got %h want 0", outs);
    end
    tick();
    rst_n   = 1'b1;
    ch_busy = 8'h00;
    dones   = 0;
    repeat (5) begin
      tick();
      if (frame_done === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_abort: dones %0d busy %b want 0/0", dones, busy);
    end
  endtask

  task automatic test_drop_sat();
    apply_reset();
    ch_en     = 8'h01;
    ch_busy   = 8'h01;
    frame_req = 1'b1;
    tick();
    tick();
    total++;
    if (pending !== 1'b1 || drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL drop_first: pending %b drop %0d want 1/0", pending, drop_cnt);
    end
    repeat (10) tick();
    total++;
    if (drop_cnt !== 8'd10) begin
      bad++;
      $display("FAIL drop_count: drop got %0d want 10", drop_cnt);
    end
    repeat (290) tick();
    total++;
    if (drop_cnt !== 8'd255) begin
      bad++;
      $display("FAIL drop_saturate: drop got %0d want 255", drop_cnt);
    end
    frame_req = 1'b0;
    tick();
    total++;
    if (drop_cnt !== 8'd255 || pending !== 1'b1) begin
      bad++;
      $display("FAIL drop_hold: drop %0d pending %b want 255/1", drop_cnt, pending);
    end
    ch_busy = 8'h00;
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_req   = 1'b0;
    ch_en       = 8'h00;
    ch_busy     = 8'h00;
    auto_en     = 1'b0;
    refresh_div = 24'd0;
    #2;
    test_reset();
    test_normal();
    test_queue();
    test_timeout();
    test_zero_mask();
    test_auto_refresh();
    test_coincident();
    test_reset_mid();
    test_drop_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
